pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage IF/Dec/Exec/Mem/WB pipeline. It observes register usage in Decode, destination registers in Exec/Mem, the branch decision (`npc_control`) from Mem and the data-memory handshake. From these it drives per-stage pipeline-register enables and flushes, plus registered forwarding selects aligned to the Exec stage. It also times out hung memory accesses and counts stall cycles.

## Interface
- `REG_ADDR_W`, 5: register index width.
- `MEM_TIMEOUT`, 16: maximum consecutive `dmem_ready`-low cycles tolerated; legal range 1–255.
- `PERF_CNT_W`, 32: stall counter width.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in REG_ADDR_W: Decode source registers.
- `id_use_rs1`, `id_use_rs2` in 1: each source is actually read.
- `ex_rd` in REG_ADDR_W, `ex_reg_write` in 1, `ex_mem_read` in 1: Exec producer.
- `mem_rd` in REG_ADDR_W, `mem_reg_write` in 1: Mem producer.
- `branch_taken` in 1: redirect from Mem (`npc_control`).
- `dmem_req` in 1: the Mem-stage instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: pipeline-register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1: load a bubble (all-zero) instead of data.
- `fwd_a`, `fwd_b` out 2: Exec operand source. 00 selects the register file, 01 the WB result, 10 `ALU_output_Mem`. Registered.
- `mem_err` out 1: sticky timeout flag.
- `stall_cycles` out PERF_CNT_W: count of cycles with `pc_en` = 0.

## Operation
- Hazard rule: a producer matches a Decode source if its `reg_write`=1, its rd equals the source register, the source's use bit is 1, and rd≠0.
- Register x0 never creates a hazard.
- The register file is write-through, so a WB producer never creates a hazard.
- FSM states: RUN, MEM_WAIT, ERROR.
- In RUN, priority is: memory wait, then branch, then data stall, then normal flow.
  - **Memory wait:** condition `dmem_req` && !`dmem_ready`. All enables are 0 and `mem_wb_flush`=1. Next state is MEM_WAIT and the wait counter is set to 1.
  - **Branch:** condition `branch_taken`. All enables are 1. `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are 1. Three younger instructions are squashed and the PC loads the target.
  - **Data stall:** `pc_en`=`if_id_en`=0 and `id_ex_flush`=1. Exec, Mem and WB advance.
  - **Normal flow:** all enables are 1 and all flushes are 0.
- MEM_WAIT:
  - While `dmem_ready`=0, outputs are the same as the memory-wait case and the counter increments.
  - When `dmem_ready`=1, all stages advance and the FSM returns to RUN. Branch and stall evaluation resume in that same cycle.
  - If the counter reaches MEM_TIMEOUT with `dmem_ready` still 0, the FSM moves to ERROR.
- ERROR: all enables are 0 and `mem_err`=1. The FSM stays here until reset.
- `branch_taken` is ignored during MEM_WAIT and ERROR.
- `fwd_a`/`fwd_b` are computed from the Decode sources:
  - 10 if the source matches an Exec producer with `ex_mem_read`=0.
  - otherwise 01 if it matches `mem_rd`.
  - otherwise 00.
  - The value is registered when `id_ex_en`=1. It is registered as 00 when `id_ex_flush`=1. Otherwise it holds.
- `stall_cycles` increments in every non-reset cycle with `pc_en`=0, including ERROR. It saturates at all-ones.

## Timing
- Enables and flushes are combinational from the current inputs and state, with zero latency.
- `fwd_*` appear one cycle after Decode evaluation, in the same cycle the consumer sits in Exec.
- Load-use with forwarding costs exactly 1 bubble.
- A taken branch costs 3 bubbles.
- A memory wait of N cycles costs N stalled cycles.
- Reset values:
  - FSM is in RUN, wait counter is 0.
  - `fwd_a` = `fwd_b` = 00, `mem_err` = 0, `stall_cycles` = 0.
  - Combinational outputs are evaluated from the RUN state.
- Asserting reset mid-wait or in ERROR returns the FSM to RUN immediately and clears the sticky flag.

## Configuration
- Macro `PIPELINE_FORWARDING_EN`.
- **Defined:**
  - The data-stall condition is a source matching the Exec producer with `ex_mem_read`=1 (load-use only).
  - `fwd_*` are generated as described in Operation.
- **Undefined:**
  - The data-stall condition is a source matching any Exec or Mem producer.
  - `fwd_a` and `fwd_b` are held at 00 and their registers are omitted.

## Test plan
- **Reset:** assert `rstn`=0 mid-stream → all five enables are 1, flushes are 0, `fwd`=00, `stall_cycles`=0.
- **ALU to ALU forwarding** (forwarding enabled): EX `add` x5 then Decode `sub` using rs1=x5 → no stall; the next cycle `fwd_a`=10.
  - A third instruction using x5 sees `fwd`=01.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=7, `id_rs2`=7 → one cycle with `pc_en`=0 and `id_ex_flush`=1; the next cycle `fwd_b`=01 and `stall_cycles`=1.
  - Without forwarding the same instruction sequence stalls 2 cycles.
- **Branch and stall together:** `branch_taken`=1 while a load-use hazard is present → flushes IF/ID, ID/EX and EX/MEM; `pc_en`=1; no stall counted.
- **Memory wait:** `dmem_req`=1 with `dmem_ready` low for 3 cycles → 3 frozen cycles with `mem_wb_flush`=1, resume on the 4th cycle; `stall_cycles`=3.
- **Timeout:** MEM_TIMEOUT=4 and `dmem_ready` held at 0 → ERROR, `mem_err`=1 sticky, enables stay 0; `rstn` pulse clears both.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stage enables/flushes, Exec forwarding selects,    |
// | data-memory timeout and stall counting. Option: PIPELINE_FORWARDING_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_err,
    output logic [PERF_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
    logic data_stall;
    logic run_eval;

    // x0 is hardwired to zero, so it never carries a dependency.
    assign ex_hit_rs1  = ex_reg_write  && id_use_rs1 && (ex_rd  == id_rs1) && (ex_rd  != '0);
    assign ex_hit_rs2  = ex_reg_write  && id_use_rs2 && (ex_rd  == id_rs2) && (ex_rd  != '0);
    assign mem_hit_rs1 = mem_reg_write && id_use_rs1 && (mem_rd == id_rs1) && (mem_rd != '0);
    assign mem_hit_rs2 = mem_reg_write && id_use_rs2 && (mem_rd == id_rs2) && (mem_rd != '0);

`ifdef PIPELINE_FORWARDING_EN
    assign data_stall = ex_mem_read && (ex_hit_rs1 || ex_hit_rs2);
`else
    assign data_stall = ex_hit_rs1 || ex_hit_rs2 || mem_hit_rs1 || mem_hit_rs2;
    logic unused_nofwd;
    assign unused_nofwd = ex_mem_read;
`endif

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        run_eval     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        case (state_q)
            ST_RUN: run_eval = 1'b1;
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    // Access completes: the pipeline moves this very cycle.
                    run_eval   = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
                    mem_wb_flush = 1'b1;
                    if (wait_cnt_q >= TIMEOUT_C) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_ERROR: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            end
            default: state_d = ST_RUN;
        endcase

        if (run_eval) begin
            if (dmem_req && !dmem_ready) begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
                mem_wb_flush = 1'b1;
                state_d      = ST_MEM_WAIT;
                wait_cnt_d   = 8'd1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (data_stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err      = (state_q == ST_ERROR);
    assign stall_cycles = stall_cnt_q;

`ifdef PIPELINE_FORWARDING_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0] sel_a, sel_b;

    // A load in Exec has no data yet, so it never selects the Mem-stage path.
    always_comb begin
        sel_a = 2'b00;
        if (ex_hit_rs1 && !ex_mem_read) begin
            sel_a = 2'b10;
        end else if (mem_hit_rs1) begin
            sel_a = 2'b01;
        end
        sel_b = 2'b00;
        if (ex_hit_rs2 && !ex_mem_read) begin
            sel_b = 2'b10;
        end else if (mem_hit_rs2) begin
            sel_b = 2'b01;
        end
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (id_ex_flush) begin
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end else if (id_ex_en) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed vectors with a scoreboard queue.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int TO = 4;
    localparam int PW = 4;
`ifdef PIPELINE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] STL = 5'b00111;
    localparam logic [4:0] FRZ = 5'b00000;
    localparam logic [3:0] F_NO = 4'b0000;
    localparam logic [3:0] F_BR = 4'b1110;
    localparam logic [3:0] F_ST = 4'b0100;
    localparam logic [3:0] F_MW = 4'b0001;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write;
    logic branch_taken, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TO),
        .PERF_CNT_W (PW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic          chk;
        logic [4:0]    en;
        logic [3:0]    fl;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          err;
        logic [PW-1:0] stall;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic [PW-1:0] exp_stall = '0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                if (e.chk) begin
                    cmp(nm, "en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
                    cmp(nm, "flush", 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), 32'(e.fl));
                    cmp(nm, "fwd_a", 32'(fwd_a), 32'(e.fa));
                    cmp(nm, "fwd_b", 32'(fwd_b), 32'(e.fb));
                    cmp(nm, "mem_err", 32'(mem_err), 32'(e.err));
                    cmp(nm, "stall", 32'(stall_cycles), 32'(e.stall));
                end
            end
        end
    end

    task automatic idle_in();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input bit c, input logic [4:0] en, input logic [3:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_t e;
        e.chk = c; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err;
        e.stall = rstn ? exp_stall : '0;
        if (!rstn) begin
            exp_stall = '0;
        end else if (!en[4] && exp_stall != {PW{1'b1}}) begin
            exp_stall = exp_stall + 1'b1;
        end
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin : stim
        logic [1:0] f10, f01;
        f10 = FWD ? 2'b10 : 2'b00;
        f01 = FWD ? 2'b01 : 2'b00;
        idle_in();

        tick(); expect_out("rst0", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); rstn = 1'b1; expect_out("rst_rel", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("idle", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        tick(); idle_in(); ex_rd = 5'd0; ex_reg_write = 1; id_rs1 = 5'd0; id_use_rs1 = 1;
        expect_out("x0", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); ex_rd = 5'd3; ex_reg_write = 1; id_rs2 = 5'd3;
        mem_rd = 5'd3; mem_reg_write = 1; id_rs1 = 5'd3;
        expect_out("nouse", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        // ALU -> ALU, then the same register one stage later
        tick(); idle_in(); ex_rd = 5'd5; ex_reg_write = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
        expect_out("alu_a", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); ex_rd = 5'd6; ex_reg_write = 1; mem_rd = 5'd5; mem_reg_write = 1;
        id_rs1 = 5'd5; id_use_rs1 = 1;
        expect_out("alu_b", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, f10, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("alu_c", 1, ALL, F_NO, f01, 2'b00, 1'b0);

        // Load-use
        tick(); idle_in(); ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
        expect_out("ld_1", 1, STL, F_ST, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); mem_rd = 5'd7; mem_reg_write = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
        expect_out("ld_2", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("ld_3", 1, ALL, F_NO, 2'b00, f01, 1'b0);

        // Exec match wins over Mem match
        tick(); idle_in(); ex_rd = 5'd9; ex_reg_write = 1; mem_rd = 5'd9; mem_reg_write = 1;
        id_rs1 = 5'd9; id_rs2 = 5'd9; id_use_rs1 = 1; id_use_rs2 = 1;
        expect_out("prio", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, 2'b00, 2'b00, 1'b0);

        // Branch beats load-use stall
        tick(); idle_in(); branch_taken = 1; ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1;
        id_rs2 = 5'd7; id_use_rs2 = 1;
        expect_out("br_ld", 1, ALL, F_BR, f10, f10, 1'b0);
        tick(); idle_in(); expect_out("br_after", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        tick(); idle_in(); ex_rd = 5'd8; ex_reg_write = 1; ex_mem_read = 1;
        mem_rd = 5'd8; mem_reg_write = 1; id_rs1 = 5'd8; id_use_rs1 = 1;
        expect_out("ld_vs_mem", 1, STL, F_ST, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); ex_rd = 5'd4; ex_reg_write = 1; id_rs1 = 5'd4; id_use_rs1 = 1;
        expect_out("pre_rst", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, 2'b00, 2'b00, 1'b0);

        // Mid-stream reset clears registered outputs at once
        tick(); idle_in(); rstn = 1'b0; expect_out("rst_mid", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); rstn = 1'b1; expect_out("rst_mid_rel", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        // Memory wait of 3 cycles; branch ignored while waiting
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; expect_out("mw1", 1, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; branch_taken = 1;
        expect_out("mw2", 1, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; expect_out("mw3", 1, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 1; expect_out("mw4", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("mw_cnt", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_ready = 0; expect_out("noreq", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        // Forward select holds while frozen; stall/branch resume on completion
        tick(); idle_in(); ex_rd = 5'd5; ex_reg_write = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
        expect_out("h0", 1, FWD ? ALL : STL, FWD ? F_NO : F_ST, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; expect_out("h1", 1, FRZ, F_MW, f10, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; expect_out("h2", 1, FRZ, F_MW, f10, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 1; ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1;
        id_rs2 = 5'd7; id_use_rs2 = 1;
        expect_out("h3_stall", 1, STL, F_ST, f10, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0; expect_out("h4", 1, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); dmem_req = 1; dmem_ready = 1; branch_taken = 1;
        expect_out("h5_br", 1, ALL, F_BR, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("h6", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        // Timeout
        tick(); idle_in(); rstn = 1'b0; expect_out("rst_t", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); rstn = 1'b1; expect_out("rst_t_rel", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < TO; i++) begin
            tick(); idle_in(); dmem_req = 1; dmem_ready = 0;
            expect_out("to_wait", 1, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        end
        tick(); idle_in(); dmem_req = 1; dmem_ready = 0;
        expect_out("to_edge", 0, FRZ, F_MW, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick(); idle_in(); dmem_req = 1; dmem_ready = 1; branch_taken = (i % 2 == 0);
            ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
            expect_out("error", 1, FRZ, F_NO, 2'b00, 2'b00, 1'b1);
        end
        tick(); idle_in(); rstn = 1'b0; expect_out("rst_err", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); rstn = 1'b1; expect_out("rst_err_rel", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);
        tick(); idle_in(); expect_out("final", 1, ALL, F_NO, 2'b00, 2'b00, 1'b0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
